// File: rtl/alu_arbiter.sv
// Two-requester round-robin wrapper around a shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module alu_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [5:0]         req_op,
    input  logic [1:0]         req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_n,
    output logic               rsp_z,
    output logic               rsp_c,
    output logic               rsp_v
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [WIDTH:0] SHMAX = WIDTH[WIDTH:0];

    state_t state_q, state_d;

    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic             id_q, id_d;
    logic             valid_q, valid_d;
    logic             rid_q, rid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic             any_valid;
    logic             gnt;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        any_valid = |req_valid;
        accept    = (state_q == IDLE) && any_valid;
        req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = ~req_valid[0];
    end
`else
    // On a tie, the requester that did not win last time goes next.
    always_comb begin
        if (&req_valid) begin
            gnt = ~last_q;
        end else begin
            gnt = req_valid[1];
        end
    end
`endif

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            3'd0: begin
                sum     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'd1:    alu_res = ({1'b0, b_q} >= SHMAX) ? '0 : a_q << b_q;
            3'd2:    alu_res = ({1'b0, b_q} >= SHMAX) ? '0 : a_q >> b_q;
            3'd3:    alu_res = a_q ^ b_q;
            3'd4:    alu_res = a_q | b_q;
            3'd5:    alu_res = ~a_q;
            3'd6:    alu_res = a_q & b_q;
            default: begin
                sum     = {1'b0, a_q} - {1'b0, b_q};
                alu_res = sum[WIDTH-1:0];
            end
        endcase
        alu_v = ((op_q == 3'd0) || (op_q == 3'd7))
              && (a_q[WIDTH-1] == b_q[WIDTH-1])
              && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        id_d    = id_q;
        valid_d = valid_q;
        rid_d   = rid_q;
        res_d   = res_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        if (accept) begin
            last_d = gnt;
            id_d   = gnt;
            a_d    = gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            b_d    = gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            op_d   = gnt ? req_op[5:3] : req_op[2:0];
            cin_d  = gnt ? req_cin[1] : req_cin[0];
        end
        if (state_q == EXEC) begin
            valid_d = 1'b1;
            rid_d   = id_q;
            res_d   = alu_res;
            n_d     = alu_res[WIDTH-1];
            z_d     = (alu_res == '0);
            c_d     = alu_c;
            v_d     = alu_v;
        end
        if ((state_q == RESP) && rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
            rid_q   <= 1'b0;
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            rid_q   <= rid_d;
            res_q   <= res_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_id     = rid_q;
    assign rsp_result = res_q;
    assign rsp_n      = n_q;
    assign rsp_z      = z_q;
    assign rsp_c      = c_q;
    assign rsp_v      = v_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against an arithmetic model.
// Honours ALU_ARB_FIXED_PRIO_EN in its grant model.
module tb_alu_arbiter;

    localparam int W = 3;

    logic           clk;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [5:0]     req_op;
    logic [1:0]     req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_n;
    logic           rsp_z;
    logic           rsp_c;
    logic           rsp_v;

    int n_cmp;
    int n_bad;
    int last_g;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_cin    (req_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .rsp_c      (rsp_c),
        .rsp_v      (rsp_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int msb(input int x);
        return (x >> (W - 1)) & 1;
    endfunction

    // Expected {result, n, z, c, v} packed as result*16 + n*8 + z*4 + c*2 + v.
    function automatic int model(input int op, input int a, input int b,
                                 input int cin);
        int m, r, c, v;
        m = 1 << W;
        c = 0;
        case (op)
            0: begin
                r = a + b + cin;
                c = (r >= m) ? 1 : 0;
                r = r % m;
            end
            1: r = (b >= W) ? 0 : (a << b) % m;
            2: r = (b >= W) ? 0 : (a >> b);
            3: r = a ^ b;
            4: r = a | b;
            5: r = (m - 1) - a;
            6: r = a & b;
            default: r = (a - b + m) % m;
        endcase
        v = ((op == 0 || op == 7) && msb(a) == msb(b) && msb(r) != msb(a)) ? 1 : 0;
        return r * 16 + msb(r) * 8 + ((r == 0) ? 4 : 0) + c * 2 + v;
    endfunction

    function automatic int exp_grant(input logic [1:0] vm);
        if (vm == 2'b01) return 0;
        if (vm == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last_g == 0) ? 1 : 0;
`endif
    endfunction

    function automatic int rsp_word();
        return {25'd0, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_word(), 0);
        check("rst_id", rsp_id, 0);
        check("rst_ready", req_ready, 0);
        @(negedge clk);
        reset  = 1'b0;
        last_g = 1;
    endtask

    task automatic run_op(input logic [1:0] vm,
                          input int a0, input int b0, input int op0, input int c0,
                          input int a1, input int b1, input int op1, input int c1,
                          input int hold, input bit keepv);
        int g, e;
        @(negedge clk);
        req_valid = vm;
        req_a     = {a1[W-1:0], a0[W-1:0]};
        req_b     = {b1[W-1:0], b0[W-1:0]};
        req_op    = {op1[2:0], op0[2:0]};
        req_cin   = {c1[0], c0[0]};
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        if (vm == 2'b00) begin
            check("idle_ready", req_ready, 0);
            @(negedge clk);
            check("idle_stay", rsp_valid, 0);
            rsp_ready = 1'b0;
            return;
        end
        g = exp_grant(vm);
        check("grant", req_ready, 1 << g);
        e = (g == 0) ? model(op0, a0, b0, c0) : model(op1, a1, b1, c1);
        @(negedge clk);
        last_g = g;
        if (!keepv) req_valid = 2'b00;
        check("exec_valid", rsp_valid, 0);
        check("exec_ready", req_ready, 0);
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, g);
        check("rsp_data", rsp_word(), e);
        check("rsp_ready", req_ready, 0);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_id", rsp_id, g);
            check("hold_data", rsp_word(), e);
            check("hold_ready", req_ready, 0);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", rsp_valid, 0);
        rsp_ready = 1'b0;
    endtask

    task automatic reset_mid_exec();
        @(negedge clk);
        req_valid = 2'b11;
        req_a     = 6'o35;
        req_b     = 6'o12;
        req_op    = 6'o00;
        req_cin   = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        reset     = 1'b1;
        #1;
        check("mid_valid", rsp_valid, 0);
        check("mid_data", rsp_word(), 0);
        check("mid_id", rsp_id, 0);
        #2;
        reset  = 1'b0;
        last_g = 1;
        @(negedge clk);
        check("mid_idle", rsp_valid, 0);
        @(negedge clk);
        check("mid_quiet", rsp_valid, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        last_g    = 1;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        do_reset();

        run_op(2'b01, 3, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        run_op(2'b10, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        run_op(2'b01, 2, 2, 7, 0, 0, 0, 0, 0, 0, 0);
        run_op(2'b01, 3, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        run_op(2'b01, 5, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        run_op(2'b10, 0, 0, 0, 0, 6, 4, 2, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, $urandom_range(0, 7), $urandom_range(0, 7), i, 1,
                   $urandom_range(0, 7), $urandom_range(0, 7), 7 - i, 0, 0, 1);
        end

        run_op(2'b11, 4, 1, 3, 0, 2, 5, 6, 0, 4, 1);

        reset_mid_exec();
        run_op(2'b11, 1, 1, 0, 1, 6, 6, 0, 1, 0, 0);

        for (int i = 0; i < 300; i++) begin
            run_op(2'($urandom_range(0, 3)),
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
